// File: rtl/data_ram_dp.sv
// True dual-port, single-clock data RAM with read handshakes, selectable
// read-during-write result, optional output register and a post-reset clear sweep.
module data_ram_dp #(
  parameter int unsigned DATA_W         = 24,
  parameter int unsigned ADDR_W         = 18,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren_a,
  input  logic              wren_b,
  input  logic              rden_a,
  input  logic              rden_b,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic              q_valid_a,
  output logic              q_valid_b,
  output logic              busy,
  output logic              collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StClear, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              same_addr;
  logic              coll_hit;
  logic              wr_a_en;
  logic              wr_b_en;
  logic              rd_a_en;
  logic              rd_b_en;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  logic [DATA_W-1:0] s1_dat_a_q;
  logic [DATA_W-1:0] s1_dat_b_q;
  logic              s1_vld_a_q;
  logic              s1_vld_b_q;
  logic              collision_q;

  assign run       = (state_q == StRun);
  assign busy      = ~run;
  assign same_addr = (address_a == address_b);
  assign coll_hit  = run & wren_a & wren_b & same_addr;
  // Port A wins a same-address write collision; B's write is dropped.
  assign wr_a_en   = run & wren_a;
  assign wr_b_en   = run & wren_b & ~coll_hit;
  assign rd_a_en   = run & rden_a;
  assign rd_b_en   = run & rden_b;
  assign collision = collision_q;

  // Read data as seen by each port, honouring the read-during-write mode.
  always_comb begin
    rd_a = mem[address_a];
    rd_b = mem[address_b];
    if (RDW_MODE != 0) begin
      if (wr_a_en) begin
        rd_a = data_a;
      end else if (wr_b_en && same_addr) begin
        rd_a = data_b;
      end
      if (wr_a_en && same_addr) begin
        rd_b = data_a;
      end else if (wr_b_en) begin
        rd_b = data_b;
      end
    end
  end

  // Array storage carries no reset: contents survive rst unless swept.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr_a_en) begin
        mem[address_a] <= data_a;
      end
      if (wr_b_en) begin
        mem[address_b] <= data_b;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
      clr_cnt_q   <= '0;
      collision_q <= 1'b0;
      s1_vld_a_q  <= 1'b0;
      s1_vld_b_q  <= 1'b0;
      s1_dat_a_q  <= '0;
      s1_dat_b_q  <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (&clr_cnt_q) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
      collision_q <= coll_hit;
      s1_vld_a_q  <= rd_a_en;
      s1_vld_b_q  <= rd_b_en;
      if (rd_a_en) begin
        s1_dat_a_q <= rd_a;
      end
      if (rd_b_en) begin
        s1_dat_b_q <= rd_b;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] q_a_q;
    logic [DATA_W-1:0] q_b_q;
    logic              q_valid_a_q;
    logic              q_valid_b_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_a_q       <= '0;
        q_b_q       <= '0;
        q_valid_a_q <= 1'b0;
        q_valid_b_q <= 1'b0;
      end else begin
        q_valid_a_q <= s1_vld_a_q;
        q_valid_b_q <= s1_vld_b_q;
        if (s1_vld_a_q) begin
          q_a_q <= s1_dat_a_q;
        end
        if (s1_vld_b_q) begin
          q_b_q <= s1_dat_b_q;
        end
      end
    end

    assign q_a       = q_a_q;
    assign q_b       = q_b_q;
    assign q_valid_a = q_valid_a_q;
    assign q_valid_b = q_valid_b_q;
  end else begin : g_no_out_reg
    // Stage-1 data only loads on a valid read, so it already holds q.
    assign q_a       = s1_dat_a_q;
    assign q_b       = s1_dat_b_q;
    assign q_valid_a = s1_vld_a_q;
    assign q_valid_b = s1_vld_b_q;
  end

endmodule

// File: tb/tb_data_ram_dp.sv
// Scoreboard bench for data_ram_dp: two instances (old-data/latency-1 and
// new-data/latency-2) driven by the same stimulus, checked against an array model.
module tb_data_ram_dp;

  localparam int DW    = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wren_a, wren_b, rden_a, rden_b;
  logic [AW-1:0] address_a, address_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] qd [4];
  logic          qv [4];
  logic          busy_w [2];
  logic          coll_w [2];

  exp_t          rq [4][$];
  int            cq [2][$];
  exp_t          e;
  int            c;
  int            checks   = 0;
  int            failures = 0;
  int            edge_n   = 0;
  int            clr_left = DEPTH;
  logic [DW-1:0] mem_m [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  data_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rst(rst), .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
    .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
    .q_a(qd[0]), .q_b(qd[1]), .q_valid_a(qv[0]), .q_valid_b(qv[1]),
    .busy(busy_w[0]), .collision(coll_w[0])
  );

  data_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .wren_a(wren_a), .wren_b(wren_b), .rden_a(rden_a), .rden_b(rden_b),
    .address_a(address_a), .address_b(address_b), .data_a(data_a), .data_b(data_b),
    .q_a(qd[2]), .q_b(qd[3]), .q_valid_a(qv[2]), .q_valid_b(qv[3]),
    .busy(busy_w[1]), .collision(coll_w[1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h (edge %0d)", name, act, req, edge_n);
    end
  endfunction

  // Monitor: every q_valid pulse pops the matching expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (qv[k]) begin
        if (rq[k].size() == 0) begin
          chk($sformatf("unexpected_q_valid[%0d]", k), 32'd1, 32'd0);
        end else begin
          e = rq[k].pop_front();
          chk($sformatf("q_data[%0d]", k), 32'(qd[k]), 32'(e.d));
          chk($sformatf("q_latency_edge[%0d]", k), edge_n, e.due);
        end
      end else if (rq[k].size() != 0 && rq[k][0].due <= edge_n) begin
        chk($sformatf("missing_q_valid[%0d]", k), 32'd0, 32'd1);
        void'(rq[k].pop_front());
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (coll_w[j]) begin
        if (cq[j].size() == 0) begin
          chk($sformatf("unexpected_collision[%0d]", j), 32'd1, 32'd0);
        end else begin
          c = cq[j].pop_front();
          chk($sformatf("collision_edge[%0d]", j), edge_n, c);
        end
      end else if (cq[j].size() != 0 && cq[j][0] <= edge_n) begin
        chk($sformatf("missing_collision[%0d]", j), 32'd0, 32'd1);
        void'(cq[j].pop_front());
      end
    end
  end

  // One clock of stimulus; entered and left at negedge+2.
  task automatic step(input logic wa, input logic ra, input int aa, input logic [DW-1:0] da,
                      input logic wb, input logic rb, input int ab, input logic [DW-1:0] db);
    logic [DW-1:0] newm [DEPTH];
    chk("busy0", 32'(busy_w[0]), 32'(rst || clr_left != 0));
    chk("busy1", 32'(busy_w[1]), 32'(rst || clr_left != 0));
    wren_a = wa; rden_a = ra; address_a = AW'(aa); data_a = da;
    wren_b = wb; rden_b = rb; address_b = AW'(ab); data_b = db;
    if (!rst && clr_left == 0) begin
      newm = mem_m;
      if (wb) newm[ab] = db;
      if (wa) newm[aa] = da;
      if (ra) begin
        rq[0].push_back('{mem_m[aa], edge_n + 1});
        rq[2].push_back('{newm[aa], edge_n + 2});
      end
      if (rb) begin
        rq[1].push_back('{mem_m[ab], edge_n + 1});
        rq[3].push_back('{newm[ab], edge_n + 2});
      end
      if (wa && wb && aa == ab) begin
        cq[0].push_back(edge_n + 1);
        cq[1].push_back(edge_n + 1);
      end
      mem_m = newm;
    end
    @(posedge clk);
    if (!rst && clr_left > 0) clr_left--;
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, '0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_q[%0d]", k), 32'(qd[k]), 32'd0);
      chk($sformatf("rst_q_valid[%0d]", k), 32'(qv[k]), 32'd0);
      rq[k].delete();
    end
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("rst_busy[%0d]", j), 32'(busy_w[j]), 32'd1);
      chk($sformatf("rst_collision[%0d]", j), 32'(coll_w[j]), 32'd0);
      cq[j].delete();
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    clr_left = DEPTH;
    idle(hold);
    rst = 1'b0;
    clr_left = DEPTH;
  endtask

  initial begin
    rst = 1'b1;
    wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
    address_a = '0; address_b = '0; data_a = '0; data_b = '0;
    @(negedge clk);
    #2;
    do_reset(2);

    // First sweep, with a request that must be dropped while busy.
    idle(4);
    step(1'b1, 1'b1, 2, 24'h555555, 1'b1, 1'b1, 3, 24'h666666);
    idle(DEPTH - 5 + 1);
    step(1'b0, 1'b1, 2, '0, 1'b0, 1'b1, 3, '0);

    // Preload, then show that the reset sweep zeroes the array.
    for (int i = 0; i < DEPTH / 2; i++)
      step(1'b1, 1'b0, i, 24'hABCDEF, 1'b1, 1'b0, i + DEPTH / 2, 24'hABCDEF);
    step(1'b0, 1'b1, 4, '0, 1'b0, 1'b1, 12, '0);
    idle(3);
    do_reset(2);
    idle(8);
    do_reset(2);
    idle(3);
    step(1'b1, 1'b0, 5, 24'h777777, 1'b0, 1'b0, 0, '0);
    idle(DEPTH - 4);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i, '0, 1'b0, 1'b1, DEPTH - 1 - i, '0);

    // Basic R/W, read-during-write and collision.
    step(1'b1, 1'b0, 3, 24'h123456, 1'b1, 1'b0, 7, 24'h00FF00);
    step(1'b0, 1'b1, 7, '0, 1'b0, 1'b1, 3, '0);
    step(1'b1, 1'b0, 5, 24'h111111, 1'b0, 1'b0, 0, '0);
    step(1'b1, 1'b0, 5, 24'h222222, 1'b0, 1'b1, 5, '0);
    step(1'b0, 1'b1, 5, '0, 1'b0, 1'b1, 5, '0);
    step(1'b1, 1'b0, 9, 24'hAAAAAA, 1'b1, 1'b1, 9, 24'hBBBBBB);
    step(1'b0, 1'b1, 9, '0, 1'b0, 1'b1, 9, '0);
    idle(2);

    // Distinct contents, then back-to-back reads in address order.
    for (int i = 0; i < DEPTH / 2; i++)
      step(1'b1, 1'b0, i, DW'(32'h010101 * (i + 1)), 1'b1, 1'b0, i + DEPTH / 2,
           DW'(32'h010101 * (i + 9)));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i, '0, 1'b0, 1'b0, 0, '0);
    idle(3);

    // Randomized traffic, narrow address range half the time for collisions.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = (n % 2 == 0) ? 3 : DEPTH - 1;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, r), DW'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, r), DW'($urandom));
      if (n == 200) begin
        step(1'b0, 1'b1, 1, '0, 1'b0, 1'b1, 2, '0);
        do_reset(1);
        idle(DEPTH);
      end
    end
    idle(4);
    for (int k = 0; k < 4; k++) chk($sformatf("drained_reads[%0d]", k), rq[k].size(), 0);
    for (int j = 0; j < 2; j++) chk($sformatf("drained_coll[%0d]", j), cq[j].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
